muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, 32, operand/result width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports src_a, src_b  input  WIDTH each  operands (a = multiplicand/dividend).
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, PREP, CALC, FIX, DONE.
REQ-013 in_ready SHALL equal (state == IDLE); a request is accepted on an edge where in_valid && in_ready.
REQ-014 On acceptance, op/src_a/src_b SHALL be registered; later input changes have no effect.
REQ-015 PREP: take absolute values of signed operands (per op signedness), record result sign; 1 cycle.
REQ-016 CALC: iterative radix-2 shift-add multiply (2*WIDTH-bit product) or restoring divide; exactly WIDTH cycles driven by an internal counter.
REQ-017 FIX: apply two's-complement sign correction and select low/high product half or quotient/remainder; 1 cycle.
REQ-018 Normal path: out_valid SHALL rise exactly WIDTH+2 cycles after the accepting edge (34 for WIDTH=32).
REQ-019 MUL returns low WIDTH bits; MULH/MULHSU/MULHU return high WIDTH bits of signed*signed, signed*unsigned, unsigned*unsigned.
REQ-020 DIV/DIVU quotient truncates toward zero; REM sign follows dividend.
REQ-021 Divide by zero: quotient all ones, remainder = src_a; IDLE -> DONE directly, out_valid 1 cycle after acceptance.
REQ-022 Signed overflow (DIV/REM, src_a = most-negative, src_b = -1): quotient = src_a, remainder 0; same 1-cycle early path.
REQ-023 DONE: out_valid high, result stable until out_valid && out_ready; then -> IDLE next cycle.
REQ-024 A new request SHALL NOT be accepted in the DONE cycle, even if out_ready is high (minimum one IDLE cycle between requests).
REQ-025 result SHALL hold its last value outside DONE.

Reset
REQ-026 On reset: state IDLE, counter 0, out_valid 0, busy 0, in_ready 1, result 0.
REQ-027 Reset in any state, including mid-CALC, SHALL abort the operation with no out_valid pulse; reset dominates in_valid.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN: when defined, ops 0-3 use a single-cycle combinational WIDTH x WIDTH multiplier, IDLE -> DONE, out_valid 1 cycle after acceptance; divides unchanged.
REQ-029 Without MULDIV_FAST_MUL_EN, all ops take the iterative path of REQ-018 and no full-width multiplier is inferred.

Verification
REQ-030 MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; out_valid at cycle 34 (iterative) or 1 (fast).
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-033 DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; all out_valid at cycle 1.
REQ-034 out_ready held low 10 cycles in DONE -> out_valid and result stable, in_ready 0; after handshake, in_ready 1 next cycle.
REQ-035 reset asserted at CALC cycle 10 of a DIV -> next cycle IDLE, in_ready 1, out_valid never asserted; subsequent MULHU 3 x 5 -> 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multicycle integer multiply/divide unit with a shift-add multiplier and a restoring divider.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier for ops 0-3.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   opa, opb;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;

    function automatic logic sgn_a(input logic [2:0] o);
        return (o == 3'd1) || (o == 3'd2) || (o == 3'd4) || (o == 3'd6);
    endfunction

    function automatic logic sgn_b(input logic [2:0] o);
        return (o == 3'd1) || (o == 3'd4) || (o == 3'd6);
    endfunction

    // Early-completion detection works on the live inputs in IDLE.
    logic             accept, div_zero, sgn_ovf, early;
    logic [WIDTH-1:0] early_res;

    assign accept   = in_valid && in_ready;
    assign div_zero = op[2] && (src_b == '0);
    assign sgn_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
                      (src_a == {1'b1, {(WIDTH-1){1'b0}}}) && (src_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*WIDTH-1:0] fa, fb, fast_prod;
    assign fa        = {{WIDTH{sgn_a(op) & src_a[WIDTH-1]}}, src_a};
    assign fb        = {{WIDTH{sgn_b(op) & src_b[WIDTH-1]}}, src_b};
    assign fast_prod = fa * fb;
    assign early     = div_zero || sgn_ovf || !op[2];
    always_comb begin
        if (!op[2])
            early_res = (op == 3'd0) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
        else if (div_zero)
            early_res = op[1] ? src_a : '1;
        else
            early_res = op[1] ? '0 : src_a;
    end
`else
    assign early = div_zero || sgn_ovf;
    always_comb begin
        if (div_zero)
            early_res = op[1] ? src_a : '1;
        else
            early_res = op[1] ? '0 : src_a;
    end
`endif

    // Operand magnitudes and iteration steps.
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, trial;
    logic [2*WIDTH-1:0] mul_step, div_step, acc_n;
    logic [WIDTH-1:0]   div_sel, fix_res;

    assign neg_a    = sgn_a(op_q) & opa[WIDTH-1];
    assign neg_b    = sgn_b(op_q) & opb[WIDTH-1];
    assign abs_a    = neg_a ? -opa : opa;
    assign abs_b    = neg_b ? -opb : opb;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    assign mul_step = {mul_sum, acc[WIDTH-1:1]};

    // Remainder lives in the upper half, quotient shifts in from the lower half.
    assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    assign div_step = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign acc_n    = neg_q ? -acc : acc;
    assign div_sel  = op_q[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

    always_comb begin
        if (op_q[2])
            fix_res = neg_q ? -div_sel : div_sel;
        else if (op_q == 3'd0)
            fix_res = acc_n[WIDTH-1:0];
        else
            fix_res = acc_n[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_nx = early ? DONE : PREP;
            end
            PREP: state_nx = CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op_q   <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q <= op;
                    opa  <= src_a;
                    opb  <= src_b;
                    if (early)
                        result <= early_res;
                end
                PREP: begin
                    cnt   <= '0;
                    acc   <= {{WIDTH{1'b0}}, op_q[2] ? abs_a : abs_b};
                    opb   <= op_q[2] ? abs_b : abs_a;
                    neg_q <= (op_q[2] && op_q[1]) ? neg_a : (neg_a ^ neg_b);
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= op_q[2] ? div_step : mul_step;
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: results, latency, handshake, stall and reset abort.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, result;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MLAT = 0;
`else
    localparam int MLAT = 34;
`endif

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Latency counts edges after the accepting edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int idx);
        int n;
        @(negedge clk);
        op = o; src_a = a; src_b = b; in_valid = 1'b1;
        chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'd4; src_a = 32'hDEADBEEF; src_b = 32'h0;
        wait_valid(n);
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(lat));
        chk($sformatf("v%0d_result", idx), result, exp);
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle_after", idx), {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MLAT};
        vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MLAT};
        vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, MLAT};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MLAT};
        vecs[4]  = '{3'd2, 32'd2,        32'hFFFFFFFF, 32'h00000001, MLAT};
        vecs[5]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MLAT};
        vecs[6]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MLAT};
        vecs[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MLAT};
        vecs[8]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[9]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[10] = '{3'd5, 32'd100,      32'd7,        32'd14,       34};
        vecs[11] = '{3'd7, 32'd100,      32'd7,        32'd2,        34};
        vecs[12] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[13] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        34};
        vecs[14] = '{3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34};
        vecs[15] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
        vecs[16] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
        vecs[17] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
        vecs[18] = '{3'd6, 32'd5,        32'd0,        32'd5,        0};
        vecs[19] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
        vecs[20] = '{3'd7, 32'd5,        32'd0,        32'd5,        0};
        vecs[21] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
        vecs[22] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0};
        vecs[23] = '{3'd1, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, MLAT};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {28'd0, in_ready, busy, out_valid, 1'b0}, 32'b1000);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, i);

        // No acceptance in DONE even with in_valid and out_ready both high.
        @(negedge clk);
        op = 3'd4; src_a = 32'd5; src_b = 32'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 3'd5; src_a = 32'd100; src_b = 32'd7;
        chk("done_no_ready", {30'd0, in_ready, out_valid}, 32'b01);
        @(posedge clk); #1;
        chk("gap_idle", {30'd0, in_ready, busy}, 32'b10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("second_accept_busy", 32'(busy), 32'd1);
        wait_valid(n);
        chk("second_latency", 32'(n), 32'd34);
        chk("second_result", result, 32'd14);
        @(posedge clk); #1;

        // Consumer stall in DONE.
        out_ready = 1'b0;
        @(negedge clk);
        op = 3'd5; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        chk("stall_latency", 32'(n), 32'd34);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall_hold%0d", k), {29'd0, out_valid, in_ready, 1'b0}, 32'b100);
            chk($sformatf("stall_result%0d", k), result, 32'd14);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {30'd0, in_ready, out_valid}, 32'b10);
        chk("result_hold_idle", result, 32'd14);

        // Reset during CALC aborts the divide.
        @(negedge clk);
        op = 3'd4; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("calc_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_idle", {29'd0, in_ready, busy, out_valid}, 32'b100);
        chk("abort_result", result, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        run_op(3'd3, 32'd3, 32'd5, 32'd0, MLAT, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
